// File: rtl/wb2ahb_bridge.sv
// Wishbone classic slave to AHB-Lite master bridge: one SINGLE transfer per WB cycle.
// Optional feature: define WB2AHB_ERR_EN to report AHB ERROR responses on err_o.
module wb2ahb_bridge #(
  parameter int WB_DATA_WIDTH = 16,
  parameter int WB_ADDR_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cyc_i,
  input  logic                       stb_i,
  input  logic                       we_i,
  input  logic [WB_ADDR_WIDTH-1:0]   adr_i,
  input  logic [WB_DATA_WIDTH-1:0]   dat_i,
  input  logic [WB_DATA_WIDTH/8-1:0] sel_i,
  output logic [WB_DATA_WIDTH-1:0]   dat_o,
  output logic                       ack_o,
  output logic                       err_o,
  output logic [WB_ADDR_WIDTH-1:0]   haddr,
  output logic [1:0]                 htrans,
  output logic                       hwrite,
  output logic [2:0]                 hsize,
  output logic [2:0]                 hburst,
  output logic [3:0]                 hprot,
  output logic [WB_DATA_WIDTH-1:0]   hwdata,
  input  logic [WB_DATA_WIDTH-1:0]   hrdata,
  input  logic                       hready,
  input  logic                       hresp
);

  localparam int         SEL_W     = WB_DATA_WIDTH / 8;
  localparam int         OFS_W     = $clog2(SEL_W);
  localparam logic [2:0] FULL_SIZE = 3'(OFS_W);
  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    RESP
  } state_t;

  state_t                     state;
  logic                       req;
  logic                       abort_p0;
  logic [WB_DATA_WIDTH-1:0]   wdat_p0;
  logic [OFS_W-1:0]           ofs;
  logic [2:0]                 size;

  assign req    = cyc_i & stb_i;
  assign hburst = 3'b000;
  assign hprot  = 4'b0011;

  // Transfer size from the byte-select pattern; irregular patterns fall back to full width.
  function automatic logic [2:0] sel_size(input logic [SEL_W-1:0] sel);
    logic [2:0] sz;
    sz = FULL_SIZE;
    for (int i = 0; i < SEL_W; i++) begin
      if (sel == SEL_W'(1 << i)) sz = 3'd0;
    end
    for (int i = 0; i + 1 < SEL_W; i += 2) begin
      if (sel == SEL_W'(3 << i)) sz = 3'd1;
    end
    if (sel == {SEL_W{1'b1}}) sz = FULL_SIZE;
    return sz;
  endfunction

  function automatic logic [OFS_W-1:0] sel_offset(input logic [SEL_W-1:0] sel);
    logic [OFS_W-1:0] o;
    o = '0;
    for (int i = 0; i < SEL_W; i++) begin
      if (sel == SEL_W'(1 << i)) o = OFS_W'(i);
    end
    for (int i = 0; i + 1 < SEL_W; i += 2) begin
      if (sel == SEL_W'(3 << i)) o = OFS_W'(i);
    end
    if (sel == {SEL_W{1'b1}}) o = '0;
    return o;
  endfunction

  assign ofs  = sel_offset(sel_i);
  assign size = sel_size(sel_i);

`ifdef WB2AHB_ERR_EN
  logic err_p0;
  assign err_o = err_p0;
`else
  logic unused_hresp;
  assign err_o        = 1'b0;
  assign unused_hresp = hresp;
`endif

  logic unused_adr_lsb;
  assign unused_adr_lsb = ^adr_i[OFS_W-1:0];

  // Write data is held until the data phase; no reset needed on this datapath register.
  always_ff @(posedge clk) begin
    if (state == IDLE && req) wdat_p0 <= dat_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      htrans   <= HT_IDLE;
      haddr    <= '0;
      hwrite   <= 1'b0;
      hsize    <= 3'd0;
      hwdata   <= '0;
      dat_o    <= '0;
      ack_o    <= 1'b0;
      abort_p0 <= 1'b0;
`ifdef WB2AHB_ERR_EN
      err_p0   <= 1'b0;
`endif
    end else begin
      ack_o <= 1'b0;
`ifdef WB2AHB_ERR_EN
      err_p0 <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (req) begin
            abort_p0 <= 1'b0;
            if (sel_i == '0) begin
              // Nothing to move: complete locally without touching the AHB side.
              state <= RESP;
              ack_o <= 1'b1;
              dat_o <= '0;
            end else begin
              state  <= ADDR;
              htrans <= HT_NONSEQ;
              haddr  <= {adr_i[WB_ADDR_WIDTH-1:OFS_W], ofs};
              hwrite <= we_i;
              hsize  <= size;
            end
          end
        end
        ADDR: begin
          if (!req) abort_p0 <= 1'b1;
          if (hready) begin
            state  <= DATA;
            htrans <= HT_IDLE;
            hwdata <= wdat_p0;
          end
        end
        DATA: begin
          if (!req) abort_p0 <= 1'b1;
          if (hready) begin
            state <= RESP;
`ifdef WB2AHB_ERR_EN
            dat_o <= (hwrite || hresp) ? '0 : hrdata;
            if (req && !abort_p0) begin
              ack_o  <= !hresp;
              err_p0 <= hresp;
            end
`else
            dat_o <= hwrite ? '0 : hrdata;
            if (req && !abort_p0) ack_o <= 1'b1;
`endif
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          htrans <= HT_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/wb2ahb_bridge.md
# wb2ahb_bridge

Wishbone classic slave to AHB-Lite master bridge; the reverse-direction companion of the ahb2wb bridge. Accepts single Wishbone read/write cycles and re-issues each as one AHB-Lite SINGLE transfer, returning read data and completion (ack/err) to the Wishbone master. Sits between a Wishbone initiator (e.g. wb agent in master mode) and an AHB-Lite slave, one transfer outstanding at a time.

## Interface
- WB_DATA_WIDTH, 16, data width on both sides; legal 16 or 32; SEL width = WB_DATA_WIDTH/8
- WB_ADDR_WIDTH, 32, address width on both sides
- clk  in  1  single clock for both ports
- rst  in  1  asynchronous, active-high reset
- cyc_i / stb_i / we_i  in  1 each  Wishbone cycle, strobe, write enable
- adr_i  in  WB_ADDR_WIDTH  Wishbone address
- dat_i  in  WB_DATA_WIDTH  Wishbone write data
- sel_i  in  WB_DATA_WIDTH/8  byte selects
- dat_o  out  WB_DATA_WIDTH  read data, valid while ack_o=1
- ack_o  out  1  normal completion, one-cycle pulse
- err_o  out  1  error completion, one-cycle pulse
- haddr  out  WB_ADDR_WIDTH; htrans out 2; hwrite out 1; hsize out 3; hburst out 3; hprot out 4
- hwdata  out  WB_DATA_WIDTH  AHB write data (data phase)
- hrdata  in  WB_DATA_WIDTH; hready in 1; hresp in 1

## Operation
- FSM: IDLE -> ADDR -> DATA -> RESP -> IDLE.
- IDLE: on cyc_i&stb_i, register adr_i, we_i, dat_i, sel_i; go ADDR. If sel_i==0, skip AHB, go RESP with ack.
- ADDR: drive htrans=NONSEQ(2'b10), haddr, hwrite, hsize; hold until hready=1, then go DATA.
- DATA: htrans=IDLE(2'b00); hwdata=registered dat_i; wait hready=1; capture hrdata and hresp; go RESP.
- RESP: ack_o or err_o high exactly one cycle; dat_o=captured hrdata (reads); return IDLE.
- hsize/haddr from sel: single byte -> hsize=000, haddr low bits = byte index; aligned byte pair -> 001, haddr low bit 0 = pair offset; all bytes -> log2(WB_DATA_WIDTH/8); any other nonzero pattern -> full width, aligned address.
- hburst=3'b000 (SINGLE), hprot=4'b0011 constant.
- cyc_i or stb_i deasserted after acceptance: AHB transfer still completes (no abort); ack_o/err_o suppressed in RESP.
- Back-to-back: request present in cycle after RESP is accepted from IDLE normally; no request sampled during RESP.

## Timing
- Reset values: state=IDLE, htrans=00, haddr=0, hwrite=0, hsize=0, hwdata=0, dat_o=0, ack_o=0, err_o=0; hburst=000, hprot=0011.
- Zero-wait-state slave: request seen at edge N, NONSEQ visible N+1, data phase N+2, ack_o at N+3 (3-cycle latency). Each hready=0 cycle in ADDR or DATA adds one cycle.
- AHB error: first response cycle (hresp=1, hready=0) held in DATA; completion on second cycle (hresp=1, hready=1).
- Reset asserted mid-transfer: all outputs return to reset values immediately (asynchronous); no ack/err generated after release.

## Configuration
- WB2AHB_ERR_EN defined: AHB ERROR response sets err_o (ack_o stays 0) in RESP; dat_o=0 on errored reads.
- Undefined: err_o tied 0; ERROR response treated as completion, ack_o pulses, read dat_o=captured hrdata.

## Test plan
- Write 16-bit: adr_i=0x1000_0004, dat_i=0xBEEF, sel_i=11, zero wait -> haddr=0x1000_0004, hsize=001, hwrite=1, hwdata=0xBEEF in data phase, ack_o at N+3.
- Byte read: adr_i=0x2000_0000, sel_i=10, hrdata=0x5A00, 2 wait states in data phase -> haddr=0x2000_0001, hsize=000, ack_o at N+5, dat_o=0x5A00.
- Error: read with two-cycle ERROR response -> with WB2AHB_ERR_EN err_o=1 for one cycle, ack_o=0, dat_o=0; without it ack_o=1, err_o=0.
- Abort: cyc_i drops the cycle after acceptance -> AHB transfer completes, no ack_o/err_o pulse, FSM back in IDLE.
- Back-to-back: stb_i held with new address after ack -> second NONSEQ 1 cycle after RESP; sel_i=00 request -> ack_o with no NONSEQ issued.
- Reset during DATA wait (hready=0): rst=1 -> htrans=00, ack_o=0 same cycle; after release, fresh write completes normally.
